trivium_word: RTL and testbench

Word-parallel Trivium keystream generator, the parametrised successor of the bit-serial Trivium core. It advances the 288-bit state by WORD_WIDTH rounds per clock and exposes a command/status interface: `init` to load key/IV, and `busy` during warm-up. Keystream is delivered on a valid/ready stream port with a one-word output register, so a downstream XOR/packet stage can stall it without losing state. It sits between the key-management register bank and the stream-cipher datapath.

---
 rtl/trivium_word.sv | 187 ++++++++++++++++++
 tb/tb_trivium_word.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trivium_word.sv
// Word-parallel Trivium keystream generator: WORD_WIDTH rounds per clock, init/busy control, valid/ready output.
// Optional accepted-word counter port ks_count is built only when TRIVIUM_WORD_CNT_EN is defined.

module trivium_word_checker #(
  parameter int WORD_WIDTH    = 8,
  parameter int WARMUP_ROUNDS = 1152,
  parameter int CW            = 11
) (
  input logic                  clk,
  input logic                  rst_n,
  input logic                  init,
  input logic                  busy,
  input logic                  ks_valid,
  input logic                  ks_ready,
  input logic [WORD_WIDTH-1:0] ks_data,
  input logic [CW-1:0]         cnt,
  input logic [1:0]            fsm
);
  a_busy_valid_excl: assert property (@(posedge clk) disable iff (!rst_n) !(busy && ks_valid));
  a_stall_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (ks_valid && !ks_ready && !init) |=> (ks_valid && $stable(ks_data)));
  a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n) cnt <= CW'(WARMUP_ROUNDS));
  a_fsm_legal: assert property (@(posedge clk) disable iff (!rst_n) fsm != 2'd3);
endmodule

module trivium_word #(
  parameter int WORD_WIDTH    = 8,
  parameter int WARMUP_ROUNDS = 1152
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  init,
  input  logic [79:0]           key,
  input  logic [79:0]           iv,
  output logic                  busy,
  output logic                  ks_valid,
  input  logic                  ks_ready,
  output logic [WORD_WIDTH-1:0] ks_data
`ifdef TRIVIUM_WORD_CNT_EN
  , output logic [31:0]         ks_count
`endif
);

  localparam int CW = $clog2(WARMUP_ROUNDS + 1);
  localparam logic [CW-1:0] CNT_STEP = CW'(WORD_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WARMUP_ROUNDS - WORD_WIDTH);
  localparam logic [CW-1:0] CNT_MAX  = CW'(WARMUP_ROUNDS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2
  } fsm_t;

  fsm_t                  fsm_r;
  logic [287:0]          state_r;
  logic [CW-1:0]         cnt_r;
  logic [287:0]          adv_s;
  logic [WORD_WIDTH-1:0] word_s;
  logic [287:0]          load_s;

  // Bit s(n) of the cipher state lives at vector index n-1.
  function automatic logic [287:0] load_state(input logic [79:0] k, input logic [79:0] v);
    logic [287:0] s;
    s          = {288{1'b0}};
    s[79:0]    = k;
    s[172:93]  = v;
    s[287:285] = 3'b111;
    return s;
  endfunction

  // One Trivium round; returns {z, next_state}.
  function automatic logic [288:0] trivium_round(input logic [287:0] s);
    logic t1;
    logic t2;
    logic t3;
    logic z;
    t1 = s[65] ^ s[92];
    t2 = s[161] ^ s[176];
    t3 = s[242] ^ s[287];
    z  = t1 ^ t2 ^ t3;
    t1 = t1 ^ (s[90] & s[91]) ^ s[170];
    t2 = t2 ^ (s[174] & s[175]) ^ s[263];
    t3 = t3 ^ (s[285] & s[286]) ^ s[68];
    return {z, s[286:177], t2, s[175:93], t1, s[91:0], t3};
  endfunction

  // Key/IV load image
  always_comb begin
    load_s = load_state(key, iv);
  end

  // Unrolled WORD_WIDTH rounds; round k produces keystream bit k
  always_comb begin
    logic [287:0] cur;
    logic [288:0] rnd;
    cur    = state_r;
    rnd    = {289{1'b0}};
    word_s = {WORD_WIDTH{1'b0}};
    for (int k = 0; k < WORD_WIDTH; k++) begin
      rnd       = trivium_round(cur);
      word_s[k] = rnd[288];
      cur       = rnd[287:0];
    end
    adv_s = cur;
  end

  // Control FSM, cipher state, warm-up counter and the one-word output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_r    <= IDLE;
      state_r  <= {288{1'b0}};
      cnt_r    <= {CW{1'b0}};
      busy     <= 1'b0;
      ks_valid <= 1'b0;
      ks_data  <= {WORD_WIDTH{1'b0}};
    end else if (init) begin
      // init wins over a simultaneous handshake: the pending word is dropped
      fsm_r    <= WARMUP;
      state_r  <= load_s;
      cnt_r    <= {CW{1'b0}};
      busy     <= 1'b1;
      ks_valid <= 1'b0;
    end else begin
      case (fsm_r)
        IDLE: begin
          busy     <= 1'b0;
          ks_valid <= 1'b0;
        end
        WARMUP: begin
          state_r <= adv_s;
          if (cnt_r == CNT_LAST) begin
            fsm_r <= RUN;
            cnt_r <= CNT_MAX;
            busy  <= 1'b0;
          end else begin
            cnt_r <= cnt_r + CNT_STEP;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          busy <= 1'b0;
          if (!ks_valid || ks_ready) begin
            state_r  <= adv_s;
            ks_data  <= word_s;
            ks_valid <= 1'b1;
          end
        end
        default: begin
          fsm_r    <= IDLE;
          busy     <= 1'b0;
          ks_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef TRIVIUM_WORD_CNT_EN
  // Count of accepted words, wrapping at 32 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ks_count <= 32'd0;
    end else if (init) begin
      ks_count <= 32'd0;
    end else if (ks_valid && ks_ready) begin
      ks_count <= ks_count + 32'd1;
    end
  end
`endif

  trivium_word_checker #(
    .WORD_WIDTH   (WORD_WIDTH),
    .WARMUP_ROUNDS(WARMUP_ROUNDS),
    .CW           (CW)
  ) u_checker (
    .clk     (clk),
    .rst_n   (rst_n),
    .init    (init),
    .busy    (busy),
    .ks_valid(ks_valid),
    .ks_ready(ks_ready),
    .ks_data (ks_data),
    .cnt     (cnt_r),
    .fsm     (fsm_r)
  );

endmodule

// File: tb/tb_trivium_word.sv
// Bench for trivium_word: bit-serial Trivium model, per-cycle compare of W=8 DUT plus W=1/W=64 equivalence instances.
module tb_trivium_word;
  localparam int W    = 8;
  localparam int WR   = 1152;
  localparam int N    = WR / W;
  localparam int MAXB = 20480;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        init     = 1'b0;
  logic [79:0] key      = 80'h0;
  logic [79:0] iv       = 80'h0;
  logic        ks_ready = 1'b0;
  logic        one      = 1'b1;
  logic        busy, ks_valid;
  logic [W-1:0] ks_data;
  logic        b1, v1, b64, v64;
  logic [0:0]  d1;
  logic [63:0] d64;
`ifdef TRIVIUM_WORD_CNT_EN
  logic [31:0] ks_count, c1, c64;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  bit exp_bits [0:MAXB-1];
  bit nxt_bits [0:MAXB-1];
  int m_e   = -1;
  int m_acc = 0;
  logic [31:0] m_cnt = 32'd0;
  bit   m_stall = 1'b0;
  logic [W-1:0] prev_data = '0;
  bit   cmp_on = 1'b0;
  bit   eq_on  = 1'b0;

  always #5 clk = ~clk;

  trivium_word #(.WORD_WIDTH(W), .WARMUP_ROUNDS(WR)) dut (
    .clk(clk), .rst_n(rst_n), .init(init), .key(key), .iv(iv),
    .busy(busy), .ks_valid(ks_valid), .ks_ready(ks_ready), .ks_data(ks_data)
`ifdef TRIVIUM_WORD_CNT_EN
    , .ks_count(ks_count)
`endif
  );

  trivium_word #(.WORD_WIDTH(1), .WARMUP_ROUNDS(WR)) u_w1 (
    .clk(clk), .rst_n(rst_n), .init(init), .key(key), .iv(iv),
    .busy(b1), .ks_valid(v1), .ks_ready(one), .ks_data(d1)
`ifdef TRIVIUM_WORD_CNT_EN
    , .ks_count(c1)
`endif
  );

  trivium_word #(.WORD_WIDTH(64), .WARMUP_ROUNDS(WR)) u_w64 (
    .clk(clk), .rst_n(rst_n), .init(init), .key(key), .iv(iv),
    .busy(b64), .ks_valid(v64), .ks_ready(one), .ks_data(d64)
`ifdef TRIVIUM_WORD_CNT_EN
    , .ks_count(c64)
`endif
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Bit-serial Trivium: fills nxt_bits with keystream after 'warm' discarded rounds
  task automatic prep(input logic [79:0] k, input logic [79:0] v, input int warm);
    bit s [1:288];
    bit t1, t2, t3, z;
    for (int i = 1; i <= 288; i++) s[i] = 1'b0;
    for (int i = 0; i < 80; i++) begin
      s[i+1]  = k[i];
      s[94+i] = v[i];
    end
    s[286] = 1'b1; s[287] = 1'b1; s[288] = 1'b1;
    for (int r = 0; r < warm + MAXB; r++) begin
      t1 = s[66] ^ s[93];
      t2 = s[162] ^ s[177];
      t3 = s[243] ^ s[288];
      z  = t1 ^ t2 ^ t3;
      t1 = t1 ^ (s[91] & s[92]) ^ s[171];
      t2 = t2 ^ (s[175] & s[176]) ^ s[264];
      t3 = t3 ^ (s[286] & s[287]) ^ s[69];
      for (int i = 288; i > 1; i--) s[i] = s[i-1];
      s[1] = t3; s[94] = t1; s[178] = t2;
      if (r >= warm) nxt_bits[r-warm] = z;
    end
  endtask

  function automatic logic [63:0] exp_word(input int idx, input int w);
    logic [63:0] r;
    r = 64'h0;
    for (int j = 0; j < w; j++) r[j] = exp_bits[idx*w+j];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Protocol-level model: edges since init, accepted words, stall flag
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_e = -1; m_acc = 0; m_cnt = 32'd0; m_stall = 1'b0;
    end else if (init) begin
      m_e = 0; m_acc = 0; m_cnt = 32'd0; m_stall = 1'b0;
      exp_bits = nxt_bits;
    end else if (m_e >= 0) begin
      m_stall = (m_e > N) && !ks_ready;
      if (m_e > N && ks_ready) begin
        m_acc++;
        m_cnt = m_cnt + 32'd1;
      end
      if (m_e < 1000000) m_e++;
    end else begin
      m_stall = 1'b0;
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("busy", 64'(busy), 64'(m_e >= 0 && m_e < N));
      chk("ks_valid", 64'(ks_valid), 64'(m_e > N));
      if (m_e < 0) chk("idle_data", 64'(ks_data), 64'h0);
      if (m_e > N && (m_acc + 1) * W <= MAXB) chk("ks_data", 64'(ks_data), exp_word(m_acc, W));
      if (m_stall) chk("stall_hold", 64'(ks_data), 64'(prev_data));
      prev_data = ks_data;
`ifdef TRIVIUM_WORD_CNT_EN
      chk("ks_count", 64'(ks_count), 64'(m_cnt));
`endif
      if (eq_on) begin
        chk("w64_busy", 64'(b64), 64'(m_e >= 0 && m_e < WR / 64));
        chk("w64_valid", 64'(v64), 64'(m_e > WR / 64));
        if (m_e > WR / 64 && m_e - (WR / 64 + 1) < 16) chk("w64_data", d64, exp_word(m_e - (WR / 64 + 1), 64));
        chk("w1_busy", 64'(b1), 64'(m_e >= 0 && m_e < WR));
        chk("w1_valid", 64'(v1), 64'(m_e > WR));
        if (m_e > WR && m_e - (WR + 1) < 1024) chk("w1_data", 64'(d1), 64'(exp_bits[m_e - (WR + 1)]));
      end
    end
  end

  initial begin
    logic [15:0] pin;
    int bc, fv, fv1, fv64, start, c;
    cmp_on = 1'b1;

    // model pin: zero key/iv, no warm-up -> rounds 0..2 give z=1, then zeros
    prep(80'h0, 80'h0, 0);
    pin = 16'h0;
    for (int j = 0; j < 16; j++) pin[j] = nxt_bits[j];
    chk("model_pin", 64'(pin), 64'h0007);

    repeat (3) tick();
    chk("reset_busy", 64'(busy), 64'h0);
    chk("reset_valid", 64'(ks_valid), 64'h0);
    chk("reset_data", 64'(ks_data), 64'h0);
    rst_n = 1'b1;
    repeat (5) tick();

    // warm-up latency, key=0 iv=0
    prep(80'h0, 80'h0, WR);
    ks_ready = 1'b1;
    init = 1'b1; tick(); init = 1'b0;
    bc = 0; fv = -1;
    for (int k = 0; k < 200; k++) begin
      if (busy) bc++;
      if (ks_valid && fv < 0) fv = k;
      tick();
    end
    chk("busy_cycles", 64'(bc), 64'd144);
    chk("first_valid", 64'(fv), 64'd145);

    // backpressure at ~30% ready
    start = m_acc; c = 0;
    while (m_acc - start < 500 && c < 6000) begin
      ks_ready = ($urandom_range(0, 9) < 3);
      tick();
      c++;
    end
    chk("bp_words_done", 64'(m_acc - start >= 500), 64'h1);

    // re-init during warm-up at counter=400
    ks_ready = 1'b1;
    key = 80'h0123_4567_89AB_CDEF_1357; iv = 80'hFEDC_BA98_7654_3210_2468;
    prep(key, iv, WR);
    init = 1'b1; tick(); init = 1'b0;
    repeat (50) tick();
    init = 1'b1; tick(); init = 1'b0;
    chk("reinit_warm_busy", 64'(busy), 64'h1);
    chk("reinit_warm_valid", 64'(ks_valid), 64'h0);
    c = 0;
    while (!ks_valid && c < 300) begin tick(); c++; end
    chk("reinit_reach_run", 64'(ks_valid), 64'h1);
    repeat (5) tick();

    // re-init in RUN coincident with a handshake
    key = 80'hA5A5_0000_FFFF_1234_5678; iv = 80'h0000_0000_0000_0000_0001;
    prep(key, iv, WR);
    chk("pre_reinit_valid", 64'(ks_valid), 64'h1);
    init = 1'b1; tick(); init = 1'b0;
    chk("reinit_run_valid", 64'(ks_valid), 64'h0);
    chk("reinit_run_busy", 64'(busy), 64'h1);
`ifdef TRIVIUM_WORD_CNT_EN
    chk("reinit_count", 64'(ks_count), 64'h0);
`endif
    repeat (170) tick();

    // width equivalence: key=0x80000000000000000000
    key = 80'h8000_0000_0000_0000_0000; iv = 80'h0;
    prep(key, iv, WR);
    eq_on = 1'b1;
    init = 1'b1; tick(); init = 1'b0;
    fv1 = -1; fv64 = -1;
    for (int k = 0; k < 2200; k++) begin
      if (v64 && fv64 < 0) fv64 = k;
      if (v1 && fv1 < 0) fv1 = k;
      tick();
    end
    chk("w64_first_valid", 64'(fv64), 64'd19);
    chk("w1_first_valid", 64'(fv1), 64'd1153);
    eq_on = 1'b0;

`ifdef TRIVIUM_WORD_CNT_EN
    // counter wrap
    ks_ready = 1'b0;
    tick();
    force dut.ks_count = 32'hFFFF_FFFE;
    m_cnt = 32'hFFFF_FFFE;
    tick();
    release dut.ks_count;
    ks_ready = 1'b1;
    repeat (3) tick();
    ks_ready = 1'b0;
    tick();
    chk("count_wrap", 64'(ks_count), 64'h1);
`endif

    // reset mid-run
    ks_ready = 1'b1;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("rst_run_busy", 64'(busy), 64'h0);
    chk("rst_run_valid", 64'(ks_valid), 64'h0);
    chk("rst_run_data", 64'(ks_data), 64'h0);
    tick(); tick();
    rst_n = 1'b1;
    repeat (50) tick();

    // reset mid-warm-up
    prep(key, iv, WR);
    init = 1'b1; tick(); init = 1'b0;
    repeat (20) tick();
    rst_n = 1'b0;
    #1;
    chk("rst_warm_busy", 64'(busy), 64'h0);
    tick();
    rst_n = 1'b1;
    repeat (10) tick();

    cmp_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
